// File: rtl/qpmm_final_red_pkg.sv
// BN254 field constants and the chunked-subtract helpers shared by the final reduction stage.
// Pure declarations: no state, no timing.
package qpmm_final_red_pkg;

    localparam int W     = 288;
    localparam int CHUNK = 64;
    localparam int NCH   = (W + CHUNK - 1) / CHUNK;

    typedef logic [W-1:0] qpmm_fp_t;

    localparam qpmm_fp_t P_BN254  = qpmm_fp_t'(256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47);
    localparam qpmm_fp_t P2_BN254 = P_BN254 << 1;

    // Chunk k of a - b - bin; bit CHUNK of the result is the borrow out.
    function automatic logic [CHUNK:0] chunk_sub(input qpmm_fp_t a, input qpmm_fp_t b,
                                                 input int k, input logic bin);
        logic [CHUNK-1:0] ac;
        logic [CHUNK-1:0] bc;
        ac = CHUNK'(a >> (k * CHUNK));
        bc = CHUNK'(b >> (k * CHUNK));
        return {1'b0, ac} - {1'b0, bc} - {{CHUNK{1'b0}}, bin};
    endfunction

    function automatic logic chunk_borrow(input qpmm_fp_t a, input qpmm_fp_t b,
                                          input int k, input logic bin);
        logic [CHUNK:0] r;
        r = chunk_sub(a, b, k, bin);
        return r[CHUNK];
    endfunction

endpackage

// File: rtl/qpmm_sub_chunk.sv
// One CHUNK-bit slice of Z - p; Z and the D chunks finished so far travel with it.
// Latency 1 cycle; no backpressure, advances every clock.
module qpmm_sub_chunk
    import qpmm_final_red_pkg::*;
#(
    parameter int K     = 0,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld,
    input  logic [TAG_W-1:0] tag,
    input  logic [W-1:0]     z,
    input  logic [W-1:0]     d,
    input  logic             bin,
    output logic             vld_q,
    output logic [TAG_W-1:0] tag_q,
    output logic [W-1:0]     z_q,
    output logic [W-1:0]     d_q,
    output logic             bout_q
);

    logic [CHUNK:0] diff;

    assign diff = chunk_sub(z, P_BN254, K, bin);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld;
    end

    // Chunks beyond W (top chunk is zero-extended) fall off the shift.
    always_ff @(posedge clk) begin
        tag_q  <= tag;
        z_q    <= z;
        d_q    <= d | (qpmm_fp_t'(diff[CHUNK-1:0]) << (K * CHUNK));
        bout_q <= diff[CHUNK];
    end

endmodule

// File: rtl/qpmm_final_red.sv
// Final reduction of QPMM output Z in [0,2p) to [0,p); issue->out_valid QPMM_LAT+NCH+2 cycles.
// Credit-gated issue_ready bounds FIFO occupancy; out_ready pops; QPMM_FINAL_RED_RANGE_CHK_EN adds err_range.
module qpmm_final_red
    import qpmm_final_red_pkg::*;
#(
    parameter int QPMM_LAT   = 36,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             issue_ready,
    input  logic [W-1:0]     z_in,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    input  logic             out_ready
`ifdef QPMM_FINAL_RED_RANGE_CHK_EN
    ,
    output logic             err_range
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             issue_acc;
    logic             pop;
    logic [CNT_W-1:0] cnt;

    assign issue_ready = (cnt != CNT_W'(FIFO_DEPTH));
    assign issue_acc   = issue_valid && issue_ready;
    assign pop         = out_valid && out_ready;

    // Outstanding ops (in flight + stored); never exceeds FIFO_DEPTH so the FIFO cannot overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({issue_acc, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    logic [QPMM_LAT-1:0]            sr_vld;
    logic [QPMM_LAT-1:0][TAG_W-1:0] sr_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_vld <= '0;
        else     sr_vld <= {sr_vld[QPMM_LAT-2:0], issue_acc};
    end

    always_ff @(posedge clk) sr_tag <= {sr_tag[QPMM_LAT-2:0], issue_tag};

    logic [NCH:0]            st_vld;
    logic [NCH:0]            st_b;
    logic [NCH:0][TAG_W-1:0] st_tag;
    logic [NCH:0][W-1:0]     st_z;
    logic [NCH:0][W-1:0]     st_d;

    assign st_vld[0] = sr_vld[QPMM_LAT-1];
    assign st_tag[0] = sr_tag[QPMM_LAT-1];
    assign st_z[0]   = z_in;
    assign st_d[0]   = '0;
    assign st_b[0]   = 1'b0;

    for (genvar k = 0; k < NCH; k++) begin : g_sub
        qpmm_sub_chunk #(.K(k), .TAG_W(TAG_W)) u_sub (
            .clk    (clk),
            .rst    (rst),
            .vld    (st_vld[k]),
            .tag    (st_tag[k]),
            .z      (st_z[k]),
            .d      (st_d[k]),
            .bin    (st_b[k]),
            .vld_q  (st_vld[k+1]),
            .tag_q  (st_tag[k+1]),
            .z_q    (st_z[k+1]),
            .d_q    (st_d[k+1]),
            .bout_q (st_b[k+1])
        );
    end

    logic             fin_vld;
    logic [TAG_W-1:0] fin_tag;
    logic [W-1:0]     fin_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fin_vld <= 1'b0;
        else     fin_vld <= st_vld[NCH];
    end

    // A final borrow means Z < p, so Z is already canonical.
    always_ff @(posedge clk) begin
        fin_tag <= st_tag[NCH];
        fin_dat <= st_b[NCH] ? st_z[NCH] : st_d[NCH];
    end

    logic [W-1:0]     mem_dat [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fin_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fin_vld) begin
            mem_dat[wr_ptr[PTR_W-1:0]] <= fin_dat;
            mem_tag[wr_ptr[PTR_W-1:0]] <= fin_tag;
        end
    end

    // Head comes straight out of storage; forced to zero when empty so reset shows 0.
    assign out_valid = (wr_ptr != rd_ptr);
    assign out_data  = out_valid ? mem_dat[rd_ptr[PTR_W-1:0]] : '0;
    assign out_tag   = out_valid ? mem_tag[rd_ptr[PTR_W-1:0]] : '0;

`ifdef QPMM_FINAL_RED_RANGE_CHK_EN
    logic [NCH-1:0] b2_q;
    logic [NCH-1:0] b2_in;

    assign b2_in = {b2_q[NCH-2:0], 1'b0};

    always_ff @(posedge clk) begin
        for (int k = 0; k < NCH; k++) b2_q[k] <= chunk_borrow(st_z[k], P2_BN254, k, b2_in[k]);
    end

    // No borrow out of the Z - 2p chain means Z >= 2p.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                               err_range <= 1'b0;
        else if (st_vld[NCH] && !b2_q[NCH-1])  err_range <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_qpmm_final_red.sv
// Directed bench for qpmm_final_red with a scoreboard of expected results and a credit model.
module tb_qpmm_final_red;

    localparam int W       = 288;
    localparam int TAG_W   = 4;
    localparam int LAT     = 36;
    localparam int DEPTH   = 8;
    localparam int TOT_LAT = 43;
    localparam logic [W-1:0] P  = 288'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
    localparam logic [W-1:0] P2 = P + P;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic [TAG_W-1:0] issue_tag;
    logic             issue_ready;
    logic [W-1:0]     z_in;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_ready;
`ifdef QPMM_FINAL_RED_RANGE_CHK_EN
    logic             err_range;
`endif

    always #5 clk = ~clk;

    qpmm_final_red dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .z_in        (z_in),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_ready   (out_ready)
`ifdef QPMM_FINAL_RED_RANGE_CHK_EN
        ,
        .err_range   (err_range)
`endif
    );

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     dat;
        logic             dc;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] zmap [int];
    logic [W-1:0] issue_z;
    logic [W-1:0] zl [4];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int mcnt   = 0;
    int t0;
    int n;
    int acc_n;

    task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_z();
        logic [W-1:0] r;
        r = '0;
        for (int j = 0; j < 9; j++) r = {r[W-33:0], 32'($urandom)};
        return r % P2;
    endfunction

    task automatic issue(input logic [TAG_W-1:0] t, input logic [W-1:0] z);
        issue_valid = 1'b1;
        issue_tag   = t;
        issue_z     = z;
    endtask

    // One clock: score this cycle's handshakes, advance, then drive Z for the new cycle.
    task automatic tick();
        logic acc;
        logic pp;
        exp_t e;
        check("issue_ready_vs_credits", W'(issue_ready), W'(mcnt != DEPTH));
        check("no_issue_while_busy", W'(issue_valid && !issue_ready), W'(0));
        acc = issue_valid && issue_ready;
        pp  = out_valid && out_ready;
        if (pp) begin
            if (sb.size() == 0) begin
                check("unexpected_out", W'(out_valid), W'(0));
            end else begin
                e = sb.pop_front();
                if (!e.dc) check("out_data", out_data, e.dat);
                check("out_tag", W'(out_tag), W'(e.tag));
            end
        end
        if (acc) begin
            e.tag = issue_tag;
            e.dat = (issue_z >= P) ? issue_z - P : issue_z;
            e.dc  = (issue_z >= P2);
            sb.push_back(e);
            zmap[cyc + LAT] = issue_z;
        end
        mcnt = mcnt + int'(acc) - int'(pp);
        @(posedge clk);
        @(negedge clk);
        cyc++;
        z_in        = zmap.exists(cyc) ? zmap[cyc] : '1;
        issue_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; issue_valid = 1'b0; issue_tag = '0; z_in = '1; out_ready = 1'b0; issue_z = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_data", out_data, '0);
        check("rst_out_tag", W'(out_tag), W'(0));
        check("rst_issue_ready", W'(issue_ready), W'(1));
`ifdef QPMM_FINAL_RED_RANGE_CHK_EN
        check("rst_err_range", W'(err_range), W'(0));
`endif
        @(negedge clk);
        rst = 1'b0;

        // Single op: latency and value
        out_ready = 1'b1;
        issue(4'd3, P + 5);
        t0 = cyc;
        tick();
        wait_valid(60);
        check("single_latency", W'(cyc - t0), W'(TOT_LAT));
        tick();

        // Boundary values back-to-back
        zl[0] = '0; zl[1] = P - 1; zl[2] = P; zl[3] = P2 - 1;
        for (int i = 0; i < 4; i++) begin
            issue(TAG_W'(i), zl[i]);
            tick();
        end
        wait_valid(60);
        for (int i = 0; i < 4; i++) begin
            check("boundary_consecutive_valid", W'(out_valid), W'(1));
            tick();
        end
        check("boundary_drained", W'(sb.size()), W'(0));

        // Backpressure: consumer stalled, launcher issues whenever allowed
        out_ready = 1'b0;
        acc_n = 0;
        for (int i = 0; i < 12; i++) begin
            if (issue_ready) begin
                issue(TAG_W'(i), rand_z());
                acc_n++;
            end
            tick();
        end
        check("bp_accepts", W'(acc_n), W'(DEPTH));
        check("bp_ready_low", W'(issue_ready), W'(0));
        repeat (50) tick();
        check("bp_ready_still_low", W'(issue_ready), W'(0));
        check("bp_fifo_full_valid", W'(out_valid), W'(1));
        out_ready = 1'b1;
        tick();
        check("bp_ready_after_pop", W'(issue_ready), W'(1));

        // Pop and issue together around the credit limit
        for (int i = 0; i < 60; i++) begin
            if (issue_ready) issue(TAG_W'(i + 5), rand_z());
            tick();
        end
        repeat (60) tick();
        check("sim_drained", W'(sb.size()), W'(0));
        check("sim_ready_idle", W'(issue_ready), W'(1));

`ifdef QPMM_FINAL_RED_RANGE_CHK_EN
        check("err_low_before", W'(err_range), W'(0));
        issue(4'h9, P2);
        tick();
        wait_valid(60);
        check("err_set", W'(err_range), W'(1));
        repeat (6) tick();
        check("err_sticky", W'(err_range), W'(1));
`endif

        // Reset with 2 results stored and 3 in flight
        out_ready = 1'b0;
        issue(4'h1, rand_z()); tick();
        issue(4'h2, rand_z()); tick();
        repeat (22) tick();
        for (int i = 0; i < 3; i++) begin
            issue(TAG_W'(i + 10), rand_z());
            tick();
        end
        repeat (20) tick();
        check("pre_rst_valid", W'(out_valid), W'(1));
        check("pre_rst_outstanding", W'(mcnt), W'(5));
        rst = 1'b1;
        #1;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_issue_ready", W'(issue_ready), W'(1));
        check("midrst_out_data", out_data, '0);
`ifdef QPMM_FINAL_RED_RANGE_CHK_EN
        check("midrst_err_clear", W'(err_range), W'(0));
`endif
        sb.delete();
        mcnt = 0;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (60) tick();
        check("post_rst_no_stale", W'(out_valid), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
